// File: rtl/trace_pkg.sv
// trace_pkg: state type, frame layout and header constants shared by the
// trace dump engine and its beat selector.
// Optional feature macro: TRACE_HDR_EN (prepends a header beat, shifts indices by 1).
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SEND   = 2'd1,
    ST_HALTED = 2'd2
  } trace_state_t;

  localparam int IDX_W = 6;

  localparam logic [15:0] HDR_MAGIC = 16'hA55A;

`ifdef TRACE_HDR_EN
  localparam logic [IDX_W-1:0] IDX_HDR   = 6'd0;
  localparam logic [IDX_W-1:0] IDX_PC    = 6'd1;
  localparam logic [IDX_W-1:0] IDX_INSTR = 6'd2;
  localparam logic [IDX_W-1:0] IDX_RF0   = 6'd3;
  localparam logic [IDX_W-1:0] IDX_MEM0  = 6'd35;
  localparam logic [IDX_W-1:0] IDX_MEM1  = 6'd36;
  localparam logic [IDX_W-1:0] FRAME_LEN = 6'd37;
`else
  localparam logic [IDX_W-1:0] IDX_PC    = 6'd0;
  localparam logic [IDX_W-1:0] IDX_INSTR = 6'd1;
  localparam logic [IDX_W-1:0] IDX_RF0   = 6'd2;
  localparam logic [IDX_W-1:0] IDX_MEM0  = 6'd34;
  localparam logic [IDX_W-1:0] IDX_MEM1  = 6'd35;
  localparam logic [IDX_W-1:0] FRAME_LEN = 6'd36;
`endif

  localparam logic [IDX_W-1:0] IDX_LAST = FRAME_LEN - 6'd1;

endpackage

// File: rtl/trace_beat_mux.sv
// trace_beat_mux: combinational selector that maps a frame beat index to its
// payload and drives the core debug read ports for that beat.
// Optional feature macro: TRACE_HDR_EN (adds the header beat source).
module trace_beat_mux
  import trace_pkg::*;
#(
  parameter logic [31:0] DM_ADDR0 = 32'h0,
  parameter logic [31:0] DM_ADDR1 = 32'h10
) (
  input  logic [IDX_W-1:0] beat_idx,
  input  logic [31:0]      pc,
  input  logic [31:0]      instr,
`ifdef TRACE_HDR_EN
  input  logic [15:0]      frame_cnt,
`endif
  input  logic [31:0]      reg_data,
  input  logic [31:0]      dm_rdata,
  output logic [4:0]       reg_sel,
  output logic [31:0]      dm_addr,
  output logic [31:0]      payload
);

  // Route the requested beat to its source; debug ports idle at 0 otherwise.
  always_comb begin
    reg_sel = '0;
    dm_addr = '0;
    payload = '0;
    if (beat_idx == IDX_PC) begin
      payload = pc;
    end else if (beat_idx == IDX_INSTR) begin
      payload = instr;
    end else if (beat_idx >= IDX_RF0 && beat_idx < IDX_MEM0) begin
      reg_sel = 5'(beat_idx - IDX_RF0);
      // x0 is architecturally zero; never trust the RF read for it.
      payload = (beat_idx == IDX_RF0) ? '0 : reg_data;
    end else if (beat_idx == IDX_MEM0) begin
      dm_addr = DM_ADDR0;
      payload = dm_rdata;
    end else if (beat_idx == IDX_MEM1) begin
      dm_addr = DM_ADDR1;
      payload = dm_rdata;
    end
`ifdef TRACE_HDR_EN
    if (beat_idx == IDX_HDR) begin
      payload = {HDR_MAGIC, frame_cnt};
    end
`endif
  end

endmodule

// File: rtl/trace_dump_engine.sv
// trace_dump_engine: on trigger, stalls the core and streams PC, instruction,
// x0..x31 and two data-memory words as one fixed-length valid/ready frame.
// Optional feature macro: TRACE_HDR_EN (header beat {A55A, frame_count}).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | core running, waiting for trig or halt_req
// ST_SEND   | core stalled, frame beats offered on the stream
// ST_HALTED | frame limit reached or fault dumped; stalled until reset
module trace_dump_engine
  import trace_pkg::*;
#(
  parameter int unsigned MAX_FRAMES = 1000,
  parameter logic [31:0] DM_ADDR0   = 32'h0,
  parameter logic [31:0] DM_ADDR1   = 32'h10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        trig,
  input  logic        halt_req,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  output logic [4:0]  reg_sel,
  input  logic [31:0] reg_data,
  output logic [31:0] dm_addr,
  input  logic [31:0] dm_rdata,
  output logic        cpu_stall,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        halted
);

  localparam logic [31:0] MAX_W = MAX_FRAMES;

  trace_state_t     state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] next_idx;
  logic [15:0]      frame_cnt;
  logic [15:0]      cnt_inc;
  logic             fault;
  logic             limit_hit;
  logic [31:0]      pc_lat;
  logic [31:0]      instr_lat;
  logic [31:0]      mux_pc;
  logic [31:0]      payload;

  // In IDLE the selector looks at beat 0 using the live PC so the first beat
  // is ready on the trigger edge; during SEND it looks one beat ahead.
  assign next_idx  = (state == ST_SEND) ? idx + 6'd1 : '0;
  assign mux_pc    = (state == ST_SEND) ? pc_lat : pc_in;
  assign cnt_inc   = (frame_cnt == 16'hFFFF) ? frame_cnt : frame_cnt + 16'd1;
  assign limit_hit = (MAX_W != 32'd0) && ({16'h0, cnt_inc} == MAX_W);

  trace_beat_mux #(
    .DM_ADDR0 (DM_ADDR0),
    .DM_ADDR1 (DM_ADDR1)
  ) u_beat_mux (
    .beat_idx  (next_idx),
    .pc        (mux_pc),
    .instr     (instr_lat),
`ifdef TRACE_HDR_EN
    .frame_cnt (frame_cnt),
`endif
    .reg_data  (reg_data),
    .dm_rdata  (dm_rdata),
    .reg_sel   (reg_sel),
    .dm_addr   (dm_addr),
    .payload   (payload)
  );

  // Frame sequencer: state, beat index, frame counter and registered stream outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= ST_IDLE;
      idx       <= '0;
      frame_cnt <= '0;
      fault     <= 1'b0;
      pc_lat    <= '0;
      instr_lat <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
      cpu_stall <= 1'b0;
      halted    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (trig || halt_req) begin
            pc_lat    <= pc_in;
            instr_lat <= instr_in;
            fault     <= halt_req;
            idx       <= '0;
            out_data  <= payload;
            out_valid <= 1'b1;
            out_last  <= 1'b0;
            cpu_stall <= 1'b1;
            state     <= ST_SEND;
          end
        end
        ST_SEND: begin
          // A fault seen mid-frame is remembered; the frame still completes.
          if (halt_req) fault <= 1'b1;
          if (out_ready) begin
            if (idx == IDX_LAST) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              idx       <= '0;
              frame_cnt <= cnt_inc;
              if (fault || halt_req || limit_hit) begin
                state  <= ST_HALTED;
                halted <= 1'b1;
              end else begin
                state     <= ST_IDLE;
                cpu_stall <= 1'b0;
              end
            end else begin
              idx      <= next_idx;
              out_data <= payload;
              out_last <= (next_idx == IDX_LAST);
            end
          end
        end
        ST_HALTED: begin
          out_valid <= 1'b0;
          cpu_stall <= 1'b1;
          halted    <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
